// File: rtl/sepconv_ctrl_pkg.sv
// Shared types and default frame geometry for the layer-5 separable
// convolution frame sequencer.
package sepconv_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_DRAIN = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_e;

  localparam int DEF_IMG_WIDHT  = 44;
  localparam int DEF_IMG_HEIGHT = 44;
  localparam int DEF_OUT_WIDHT  = 44;
  localparam int DEF_OUT_HEIGHT = 44;
  localparam int DEF_TIMEOUT    = 1024;
  localparam int DEF_CNT_W      = 16;

  localparam int IN_PIXELS  = DEF_IMG_WIDHT * DEF_IMG_HEIGHT;
  localparam int OUT_PIXELS = DEF_OUT_WIDHT * DEF_OUT_HEIGHT;

  // Pixel count of a width x height frame.
  function automatic int pixels(input int w, input int h);
    return w * h;
  endfunction

endpackage

// File: rtl/sepconv_l5_frame_sequencer_pos_counter.sv
// Column/row position counter with clear, enable and wrap. Once the row
// reaches HEIGHT the position holds at (0, HEIGHT) until cleared.
module frame_pos_counter #(
  parameter int WIDTH  = 44,
  parameter int HEIGHT = 44,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] col_o,
  output logic [CNT_W-1:0] row_o,
  output logic             last_o
);

  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(HEIGHT - 1);
  localparam logic [CNT_W-1:0] ROW_END  = CNT_W'(HEIGHT);

  logic [CNT_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] row_q, row_d;

  // Next position: clear wins, otherwise step with wrap, saturating at the end row.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr_i) begin
      col_d = '0;
      row_d = '0;
    end else if (en_i && (row_q < ROW_END)) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = row_q + CNT_W'(1);
      end else begin
        col_d = col_q + CNT_W'(1);
      end
    end
  end

  // Position registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col_o  = col_q;
  assign row_o  = row_q;
  assign last_o = (col_q == COL_LAST) && (row_q == ROW_LAST);

endmodule

// File: rtl/sepconv_l5_frame_sequencer.sv
// Frame-level controller for the layer-5 separable convolution datapath:
// gates the upstream pixel stream into Valid_In one frame at a time, counts
// input/output pixels, and flags stalled or over-producing pipelines.
module sepconv_l5_frame_sequencer
  import sepconv_ctrl_pkg::*;
#(
  parameter int IMG_WIDHT  = DEF_IMG_WIDHT,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int OUT_WIDHT  = DEF_OUT_WIDHT,
  parameter int OUT_HEIGHT = DEF_OUT_HEIGHT,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             src_valid,
  output logic             src_ready,
  output logic             conv_valid_in,
  input  logic             conv_valid_out,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] in_col,
  output logic [CNT_W-1:0] in_row,
  output logic [CNT_W-1:0] out_cnt
);

  localparam logic [CNT_W-1:0] OUT_PIX_C = CNT_W'(pixels(OUT_WIDHT, OUT_HEIGHT));
  localparam logic [CNT_W-1:0] TMO_C     = CNT_W'(TIMEOUT);

  state_e           state_q;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic             done_q, err_q;
  logic             counting, overrun, in_last, pos_clr;

  assign src_ready     = (state_q == S_LOAD);
  assign conv_valid_in = src_valid && src_ready;
  assign counting      = (state_q == S_LOAD) || (state_q == S_DRAIN);
  assign busy          = counting;
  assign done          = done_q;
  assign err           = err_q;
  assign out_cnt       = out_cnt_q;

  // A new frame (or an abort) restarts the input position from the origin.
  assign pos_clr = abort || (start && ((state_q == S_IDLE) || (state_q == S_ERR)));

  frame_pos_counter #(
    .WIDTH  (IMG_WIDHT),
    .HEIGHT (IMG_HEIGHT),
    .CNT_W  (CNT_W)
  ) u_in_pos (
    .clk    (clk),
    .rst_ni (rst),
    .clr_i  (pos_clr),
    .en_i   (conv_valid_in),
    .col_o  (in_col),
    .row_o  (in_row),
    .last_o (in_last)
  );

  // Output-beat and idle-timeout next values; a beat always beats the timeout.
  always_comb begin
    overrun   = counting && conv_valid_out && (out_cnt_q == OUT_PIX_C);
    out_cnt_d = out_cnt_q;
    if (counting && conv_valid_out && !overrun) begin
      out_cnt_d = out_cnt_q + CNT_W'(1);
    end
    tmo_d = tmo_q;
    if (state_q == S_DRAIN) begin
      if (conv_valid_out) begin
        tmo_d = '0;
      end else if (tmo_q != TMO_C) begin
        tmo_d = tmo_q + CNT_W'(1);
      end
    end
  end

  // Frame FSM with registered done/err flags; abort outranks start and transitions.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      out_cnt_q <= '0;
      tmo_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else if (abort) begin
      state_q   <= S_IDLE;
      out_cnt_q <= '0;
      tmo_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_ERR: begin
          if (start) begin
            state_q   <= S_LOAD;
            out_cnt_q <= '0;
            tmo_q     <= '0;
            err_q     <= 1'b0;
          end
        end
        S_LOAD: begin
          out_cnt_q <= out_cnt_d;
          tmo_q     <= '0;
          if (overrun) begin
            state_q <= S_ERR;
            err_q   <= 1'b1;
          end else if (conv_valid_in && in_last) begin
            // Zero-latency datapaths can finish on the very last input beat.
            if (out_cnt_d == OUT_PIX_C) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          out_cnt_q <= out_cnt_d;
          tmo_q     <= tmo_d;
          if (overrun) begin
            state_q <= S_ERR;
            err_q   <= 1'b1;
          end else if (out_cnt_d == OUT_PIX_C) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else if (tmo_d == TMO_C) begin
            state_q <= S_ERR;
            err_q   <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
